// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan blocks.
// Defining SEG_HEX_EN extends the digit decode to hex values A..F.
package seg_pkg;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  localparam int ENT_BLANK = 5;
  localparam int ENT_DP    = 4;
  localparam int ENT_VAL_H = 3;
  localparam int ENT_VAL_L = 0;

  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [3:0] DIG_OFF     = 4'hF;
  localparam logic [5:0] ENTRY_BLANK = 6'b100000;

  // Active-high {A..G,Dp} pattern with Dp cleared; unsupported values are dark.
  function automatic logic [7:0] seg_pattern(input logic [3:0] val);
    logic [7:0] pat;
    pat = 8'h00;
    case (val)
      4'd0: pat = 8'hFC;
      4'd1: pat = 8'h60;
      4'd2: pat = 8'hDA;
      4'd3: pat = 8'hF2;
      4'd4: pat = 8'h66;
      4'd5: pat = 8'hB6;
      4'd6: pat = 8'hBE;
      4'd7: pat = 8'hE0;
      4'd8: pat = 8'hFE;
      4'd9: pat = 8'hF6;
`ifdef SEG_HEX_EN
      4'd10: pat = 8'hEE;
      4'd11: pat = 8'h3E;
      4'd12: pat = 8'h9C;
      4'd13: pat = 8'h7A;
      4'd14: pat = 8'h9E;
      4'd15: pat = 8'h8E;
`endif
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational digit entry {BLANK,DP,VAL} -> active-low {A..G,Dp}; no latency, no flow control.
// Hex values A..F light only when SEG_HEX_EN is defined.
module seg_decode
  import seg_pkg::*;
(
  input  logic [5:0] i_entry,
  output logic [7:0] o_seg
);

  logic [7:0] w_pat;

  always_comb begin
    w_pat = seg_pattern(i_entry[ENT_VAL_H:ENT_VAL_L]);
    if (i_entry[ENT_BLANK]) begin
      w_pat = 8'h00;
    end
    w_pat[0] = i_entry[ENT_DP];
    o_seg    = ~w_pat;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scanner with shadow/active banks; outputs registered, one CLK after each transition.
// Writes stall (WR_READY=0) from COMMIT until the shadow bank is copied at the next frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV_W       = 4,
  parameter int ON_TICKS    = 6,
  parameter int BLANK_TICKS = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [1:0] WR_ADDR,
  input  logic [5:0] WR_DATA,
  input  logic       COMMIT,
  output logic [7:0] SEG,
  output logic [3:0] DIG,
  output logic       FRAME_DONE
);

  localparam logic [7:0] ON_LAST    = 8'(ON_TICKS - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_TICKS - 1);

  logic [DIV_W-1:0] r_presc;
  scan_state_t      r_state;
  logic [7:0]       r_tcnt;
  logic [1:0]       r_idx;
  logic [5:0]       r_shadow [4];
  logic [5:0]       r_active [4];
  logic             r_pending;
  logic [7:0]       r_seg;
  logic [3:0]       r_dig;
  logic             r_frame_done;

  scan_state_t      w_state_nxt;
  logic [7:0]       w_tcnt_nxt;
  logic [1:0]       w_idx_nxt;
  logic             w_tick;
  logic             w_frame;
  logic             w_wr_fire;
  logic [7:0]       w_seg_show;

  assign w_tick    = &r_presc;
  assign w_wr_fire = WR_VALID && !r_pending;

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_idx_nxt   = r_idx;
    w_frame     = 1'b0;
    if (w_tick) begin
      case (r_state)
        BLANK: begin
          if (r_tcnt == BLANK_LAST) begin
            w_state_nxt = SHOW;
            w_tcnt_nxt  = 8'd0;
          end else begin
            w_tcnt_nxt = r_tcnt + 8'd1;
          end
        end
        SHOW: begin
          if (r_tcnt == ON_LAST) begin
            w_state_nxt = BLANK;
            w_tcnt_nxt  = 8'd0;
            w_idx_nxt   = r_idx + 2'd1;
            w_frame     = (r_idx == 2'd3);
          end else begin
            w_tcnt_nxt = r_tcnt + 8'd1;
          end
        end
        default: w_state_nxt = BLANK;
      endcase
    end
  end

  // Decoding the upcoming digit lets the output register line up with the state register.
  seg_decode u_decode (
    .i_entry (r_active[w_idx_nxt]),
    .o_seg   (w_seg_show)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc      <= '0;
      r_state      <= BLANK;
      r_tcnt       <= 8'd0;
      r_idx        <= 2'd0;
      r_seg        <= SEG_OFF;
      r_dig        <= DIG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= r_presc + 1'b1;
      r_state      <= w_state_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_done <= w_frame;
      if (w_state_nxt == SHOW) begin
        r_seg <= w_seg_show;
        r_dig <= ~(4'b1000 >> w_idx_nxt);
      end else begin
        r_seg <= SEG_OFF;
        r_dig <= DIG_OFF;
      end
    end
  end

  // The copy only happens while pending, when writes are stalled, so the shadow is stable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= ENTRY_BLANK;
        r_active[i] <= ENTRY_BLANK;
      end
    end else begin
      if (w_wr_fire) begin
        r_shadow[WR_ADDR] <= WR_DATA;
      end
      if (w_frame && r_pending) begin
        r_pending <= 1'b0;
        for (int i = 0; i < 4; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end else if (COMMIT) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign WR_READY   = ~r_pending;
  assign SEG        = r_seg;
  assign DIG        = r_dig;
  assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: blank scan, bank commit, write stall, DP, reset mid-frame.
module tb_seg_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       WR_VALID;
  logic       WR_READY;
  logic [1:0] WR_ADDR;
  logic [5:0] WR_DATA;
  logic       COMMIT;
  logic [7:0] SEG;
  logic [3:0] DIG;
  logic       FRAME_DONE;

  int n_chk = 0;
  int n_err = 0;

`ifdef SEG_HEX_EN
  localparam logic [7:0] A_EXP = 8'h11;
`else
  localparam logic [7:0] A_EXP = 8'hFF;
`endif

  seg_scan_ctrl dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .COMMIT     (COMMIT),
    .SEG        (SEG),
    .DIG        (DIG),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [5:0] d, output int waits);
    WR_VALID = 1'b1;
    WR_ADDR  = a;
    WR_DATA  = d;
    waits    = 0;
    while (!WR_READY && waits < 2000) begin
      step(1);
      waits++;
    end
    check("wr_rdy", 32'(WR_READY), 32'd1);
    step(1);
    WR_VALID = 1'b0;
  endtask

  task automatic commit_pulse();
    COMMIT = 1'b1;
    step(1);
    COMMIT = 1'b0;
  endtask

  // Starts on the cycle the prescaler reads 0 in BLANK for D1; ends on the next such cycle.
  task automatic scan_frame(input string nm, input logic [31:0] segs);
    logic [15:0] dig_tab;
    dig_tab = 16'h7BDE;
    for (int k = 0; k < 4; k++) begin
      step(16);
      check($sformatf("%s_gap_dig%0d", nm, k), 32'(DIG), 32'hF);
      check($sformatf("%s_gap_seg%0d", nm, k), 32'(SEG), 32'hFF);
      check($sformatf("%s_gap_fd%0d", nm, k), 32'(FRAME_DONE), 32'd0);
      step(64);
      check($sformatf("%s_dig%0d", nm, k), 32'(DIG), 32'(dig_tab[15-4*k -: 4]));
      check($sformatf("%s_seg%0d", nm, k), 32'(SEG), 32'(segs[31-8*k -: 8]));
      step(48);
    end
    check($sformatf("%s_frame_done", nm), 32'(FRAME_DONE), 32'd1);
  endtask

  initial begin
    int w;
    RST_N    = 1'b0;
    WR_VALID = 1'b0;
    WR_ADDR  = 2'd0;
    WR_DATA  = 6'd0;
    COMMIT   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_seg", 32'(SEG), 32'hFF);
    check("rst_dig", 32'(DIG), 32'hF);
    check("rst_fd", 32'(FRAME_DONE), 32'd0);
    check("rst_rdy", 32'(WR_READY), 32'd1);
    RST_N = 1'b1;

    fork
      begin
        scan_frame("f0", 32'hFFFF_FFFF);
        scan_frame("f1", 32'hFFFF_FFFF);
        scan_frame("f2", 32'h9F25_0D99);
        scan_frame("f3", 32'h0925_1E99);
        scan_frame("f4", {8'h09, A_EXP, 8'h1E, 8'hFE});
      end
      begin
        int hw;
        step(4);
        wr(2'd0, 6'h01, hw);
        wr(2'd1, 6'h02, hw);
        wr(2'd2, 6'h03, hw);
        wr(2'd3, 6'h04, hw);
        step(512);
        commit_pulse();
        check("rdy_lo", 32'(WR_READY), 32'd0);
        step(79);
        wr(2'd0, 6'h09, hw);
        check("hold_wait", 32'(hw), 32'd424);
        step(75);
        WR_VALID = 1'b1;
        WR_ADDR  = 2'd2;
        WR_DATA  = 6'b010111;
        COMMIT   = 1'b1;
        check("wr_commit_rdy", 32'(WR_READY), 32'd1);
        step(1);
        WR_VALID = 1'b0;
        COMMIT   = 1'b0;
        step(499);
        wr(2'd1, 6'h0A, hw);
        wr(2'd3, 6'b110000, hw);
        commit_pulse();
        check("rdy_lo2", 32'(WR_READY), 32'd0);
      end
    join

    wr(2'd0, 6'h08, w);
    commit_pulse();
    step(78);
    check("mid_dig", 32'(DIG), 32'h7);
    check("mid_seg", 32'(SEG), 32'h09);
    check("mid_rdy", 32'(WR_READY), 32'd0);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_seg", 32'(SEG), 32'hFF);
    check("arst_dig", 32'(DIG), 32'hF);
    check("arst_fd", 32'(FRAME_DONE), 32'd0);
    check("arst_rdy", 32'(WR_READY), 32'd1);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    check("post_rst_rdy", 32'(WR_READY), 32'd1);
    scan_frame("f6", 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
